// File: rtl/mem_rd_ctrl.sv
// Read-side sequencer: issues N consecutive row reads per bank from a latched base address.
// Lane k optionally lags lane 0 by k cycles to give the systolic array its diagonal skew.
module mem_rd_ctrl #(
  parameter int SYS_ROW    = 16,
  parameter int SYS_COL    = 16,
  parameter int DATA_WIDTH = 16,
  parameter int ACCUM_SIZE = 4096,
  parameter int ADDR_WIDTH = 8,
  parameter int SKEW_EN    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_start,
  input  logic [DATA_WIDTH-1:0] num_row,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic [SYS_ROW-1:0]    rd_en_out,
  output logic [ADDR_WIDTH-1:0] rd_addr [SYS_ROW],
  output logic                  busy,
  output logic                  rd_done
);

  localparam int ACCUM_ROW = ACCUM_SIZE / SYS_COL;
  localparam logic [DATA_WIDTH-1:0] ACCUM_ROW_W = DATA_WIDTH'(ACCUM_ROW);
  localparam logic [DATA_WIDTH-1:0] DRAIN_LAST  = DATA_WIDTH'((SYS_ROW > 1) ? SYS_ROW - 2 : 0);
  localparam bit USE_DRAIN = (SKEW_EN != 0) && (SYS_ROW > 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   n_q, n_d;
  logic [DATA_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [DATA_WIDTH-1:0]   n_clamped;
  logic                    lane0_en;
  logic [ADDR_WIDTH-1:0]   lane0_addr;
  logic [SYS_ROW-1:0]      en_q;
  logic [ADDR_WIDTH-1:0]   addr_q [SYS_ROW];
  logic                    busy_q, done_q;

  always_comb n_clamped = (num_row > ACCUM_ROW_W) ? ACCUM_ROW_W : num_row;

  // NOTE: every signal gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    unique case (state_q)
      IDLE: begin
        if (rd_start) begin
          n_d     = n_clamped;
          base_d  = base_addr;
          cnt_d   = '0;
          state_d = (n_clamped == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (cnt_q == n_q - DATA_WIDTH'(1)) begin
          cnt_d   = '0;
          state_d = USE_DRAIN ? DRAIN : DONE;
        end else begin
          cnt_d = cnt_q + DATA_WIDTH'(1);
        end
      end
      // The counter is reused to wait for the trailing lanes to finish.
      DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + DATA_WIDTH'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lane0_en   = (state_q == ISSUE);
    lane0_addr = lane0_en ? base_q + ADDR_WIDTH'(cnt_q) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
      base_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      busy_q  <= (state_q != IDLE);
      done_q  <= (state_q == DONE);
    end
  end

  // NOTE: the address pipeline is reset too; it is a few flops and guarantees zeros outside each window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q <= '0;
      for (int k = 0; k < SYS_ROW; k++) addr_q[k] <= '0;
    end else begin
      en_q[0]   <= lane0_en;
      addr_q[0] <= lane0_addr;
      for (int k = 1; k < SYS_ROW; k++) begin
        if (SKEW_EN != 0) begin
          en_q[k]   <= en_q[k-1];
          addr_q[k] <= addr_q[k-1];
        end else begin
          en_q[k]   <= lane0_en;
          addr_q[k] <= lane0_addr;
        end
      end
    end
  end

  assign rd_en_out = en_q;
  assign rd_addr   = addr_q;
  assign busy      = busy_q;
  assign rd_done   = done_q;

endmodule

// File: tb/tb_mem_rd_ctrl.sv
// Directed bench for mem_rd_ctrl: a skewed and an unskewed 4-lane instance driven by hand-built commands.
module tb_mem_rd_ctrl;

  localparam int SR = 4;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_s, start_p;
  logic [DW-1:0] num_row;
  logic [AW-1:0] base;

  logic [SR-1:0] en_s, en_p;
  logic [AW-1:0] addr_s [SR];
  logic [AW-1:0] addr_p [SR];
  logic          busy_s, busy_p, done_s, done_p;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_rd_ctrl #(.SYS_ROW(SR), .SYS_COL(16), .DATA_WIDTH(DW), .ACCUM_SIZE(4096),
                .ADDR_WIDTH(AW), .SKEW_EN(1)) dut_s (
    .clk(clk), .rst(rst), .rd_start(start_s), .num_row(num_row), .base_addr(base),
    .rd_en_out(en_s), .rd_addr(addr_s), .busy(busy_s), .rd_done(done_s)
  );

  mem_rd_ctrl #(.SYS_ROW(SR), .SYS_COL(16), .DATA_WIDTH(DW), .ACCUM_SIZE(4096),
                .ADDR_WIDTH(AW), .SKEW_EN(0)) dut_p (
    .clk(clk), .rst(rst), .rd_start(start_p), .num_row(num_row), .base_addr(base),
    .rd_en_out(en_p), .rd_addr(addr_p), .busy(busy_p), .rd_done(done_p)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs t edges after the accept edge, for a command of n (clamped) rows.
  task automatic check_window(input bit par, input int t, input logic [AW-1:0] b, input int n);
    int            sk;
    int            done_t;
    int            lo;
    bit            act;
    logic [SR-1:0] exp_en;
    logic [AW-1:0] exp_a;
    string         pfx;
    sk     = par ? 0 : 1;
    pfx    = par ? "par" : "skew";
    done_t = (n == 0) ? 1 : 1 + n + (SR - 1) * sk;
    exp_en = '0;
    for (int k = 0; k < SR; k++) begin
      lo        = 1 + k * sk;
      act       = (n > 0) && (t >= lo) && (t < lo + n);
      exp_en[k] = act;
      exp_a     = act ? b + AW'(t - lo) : '0;
      check($sformatf("%s t%0d lane%0d addr", pfx, t, k), 32'(par ? addr_p[k] : addr_s[k]), 32'(exp_a));
    end
    check($sformatf("%s t%0d en", pfx, t), 32'(par ? en_p : en_s), 32'(exp_en));
    check($sformatf("%s t%0d busy", pfx, t), 32'(par ? busy_p : busy_s), 32'((t >= 1) && (t <= done_t)));
    check($sformatf("%s t%0d done", pfx, t), 32'(par ? done_p : done_s), 32'(t == done_t));
  endtask

  task automatic issue(input bit par, input logic [AW-1:0] b, input logic [DW-1:0] n);
    base    = b;
    num_row = n;
    if (par) start_p = 1'b1;
    else     start_s = 1'b1;
    tick();
    start_s = 1'b0;
    start_p = 1'b0;
  endtask

  task automatic run_cmd(input bit par, input logic [AW-1:0] b, input logic [DW-1:0] n,
                         input int n_exp, input int cycles);
    issue(par, b, n);
    for (int t = 1; t <= cycles; t++) begin
      tick();
      check_window(par, t, b, n_exp);
    end
  endtask

  initial begin
    int cnt [SR];
    rst     = 1'b1;
    start_s = 1'b0;
    start_p = 1'b0;
    num_row = '0;
    base    = '0;
    repeat (2) tick();
    check_window(1'b0, 0, 8'h00, 0);
    check_window(1'b1, 0, 8'h00, 0);
    rst = 1'b0;
    tick();

    // Skewed command: lane3 trails lane0 by three cycles, done at E+7.
    run_cmd(1'b0, 8'h10, 16'd3, 3, 9);

    // Parallel lanes: all lanes at E+1,E+2, done at E+3.
    run_cmd(1'b1, 8'h05, 16'd2, 2, 4);

    // Address wraps modulo 256.
    run_cmd(1'b0, 8'hFE, 16'd4, 4, 9);

    // Empty command: done at E+1, no enables.
    run_cmd(1'b0, 8'h33, 16'd0, 0, 3);

    // Clamp: 300 requested, 256 rows per lane.
    for (int k = 0; k < SR; k++) cnt[k] = 0;
    issue(1'b0, 8'h00, 16'd300);
    for (int t = 1; t <= 262; t++) begin
      tick();
      for (int k = 0; k < SR; k++) if (en_s[k]) cnt[k]++;
      check_window(1'b0, t, 8'h00, 256);
    end
    for (int k = 0; k < SR; k++) check($sformatf("clamp lane%0d count", k), 32'(cnt[k]), 32'd256);

    // A start during an active command is ignored; one right after rd_done is accepted.
    issue(1'b0, 8'h10, 16'd3);
    for (int t = 1; t <= 7; t++) begin
      tick();
      check_window(1'b0, t, 8'h10, 3);
      if (t == 1) begin
        start_s = 1'b1;
        base    = 8'h40;
        num_row = 16'd5;
      end else if (t == 2) begin
        start_s = 1'b0;
      end
    end
    run_cmd(1'b0, 8'h30, 16'd2, 2, 8);

    // Reset while lane0 is at j=1: outputs clear at once, no rd_done afterwards.
    issue(1'b0, 8'h10, 16'd5);
    tick();
    check_window(1'b0, 1, 8'h10, 5);
    tick();
    check_window(1'b0, 2, 8'h10, 5);
    rst = 1'b1;
    #1;
    check_window(1'b0, 0, 8'h00, 0);
    tick();
    rst = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tick();
      check_window(1'b0, 0, 8'h00, 0);
    end
    run_cmd(1'b0, 8'h20, 16'd1, 1, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
